// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register_file write port, with a 32-entry busy scoreboard.
// Latency: one cycle from handshake to write_en/rd/rd_data; readable in the register file one cycle later.
// Backpressure: the losing requester sees ready low; alloc_ready drops on a WAW hazard.
module regfile_wb_arbiter #(
  parameter int xlen = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req0_valid,
  input  logic [4:0]      req0_rd,
  input  logic [xlen-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4:0]      req1_rd,
  input  logic [xlen-1:0] req1_data,
  output logic            req1_ready,
  input  logic            alloc_valid,
  input  logic [4:0]      alloc_rd,
  output logic            alloc_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [4:0]      rd,
  output logic [xlen-1:0] rd_data,
  output logic            write_en
);

  logic [31:0]     busy;
  logic [31:0]     busy_nxt;
  logic            prio;
  logic            grant0;
  logic            grant1;
  logic            hs;
  logic [4:0]      sel_rd;
  logic [xlen-1:0] sel_data;

  // prio=0 favours req0 under contention; a lone valid requester always wins.
  assign grant0 = rstn & req0_valid & (~req1_valid | ~prio);
  assign grant1 = rstn & req1_valid & (~req0_valid | prio);
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign hs       = grant0 | grant1;
  assign sel_rd   = grant1 ? req1_rd : req0_rd;
  assign sel_data = grant1 ? req1_data : req0_data;

  assign alloc_ready = rstn & ((alloc_rd == 5'd0) | ~busy[alloc_rd]);
  assign rs1_busy    = busy[rs1];
  assign rs2_busy    = busy[rs2];

  // Clear applies first so a same-edge reservation of the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (write_en) busy_nxt[rd] = 1'b0;
    if (alloc_valid && alloc_ready && (alloc_rd != 5'd0)) busy_nxt[alloc_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy     <= '0;
      prio     <= 1'b0;
      write_en <= 1'b0;
      rd       <= '0;
      rd_data  <= '0;
    end else begin
      busy     <= busy_nxt;
      write_en <= hs && (sel_rd != 5'd0);
      if (hs) begin
        rd      <= sel_rd;
        rd_data <= sel_data;
        prio    <= grant0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rstn;
  logic            req0_valid, req1_valid, alloc_valid;
  logic [4:0]      req0_rd, req1_rd, alloc_rd, rs1, rs2;
  logic [XLEN-1:0] req0_data, req1_data;
  logic            req0_ready, req1_ready, alloc_ready, rs1_busy, rs2_busy, write_en;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_data;

  regfile_wb_arbiter #(.xlen(XLEN)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd(rd), .rd_data(rd_data), .write_en(write_en)
  );

  always #5 clk = ~clk;

  // Stand-in for register_file: captures on the edge where write_en is seen high.
  logic [XLEN-1:0] tb_rf [32];
  always @(posedge clk) if (write_en) tb_rf[rd] <= rd_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: set of pending registers, next-favoured requester, pending write, register contents.
  bit              m_busy [32];
  bit              m_ptr;
  bit              m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  logic [XLEN-1:0] m_rf [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_ptr = 1'b0; m_we = 1'b0; m_rd = '0; m_data = '0;
  endtask

  // One cycle: drive at negedge, check just after, advance model at posedge.
  task automatic step(input bit v0, input logic [4:0] r0, input logic [XLEN-1:0] d0,
                      input bit v1, input logic [4:0] r1, input logic [XLEN-1:0] d1,
                      input bit av, input logic [4:0] ar, input logic [4:0] s1, input logic [4:0] s2);
    bit g0, g1, ar_exp;
    req0_valid = v0; req0_rd = r0; req0_data = d0;
    req1_valid = v1; req1_rd = r1; req1_data = d1;
    alloc_valid = av; alloc_rd = ar; rs1 = s1; rs2 = s2;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (rstn) begin
      if (v0 && v1) begin g0 = !m_ptr; g1 = m_ptr; end
      else begin g0 = v0; g1 = v1; end
    end
    ar_exp = rstn && (ar == 5'd0 || !m_busy[ar]);
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("alloc_ready", alloc_ready, ar_exp);
    chk("rs1_busy", rs1_busy, m_busy[s1]);
    chk("rs2_busy", rs2_busy, m_busy[s2]);
    chk("write_en", write_en, m_we);
    chk("rd", rd, m_rd);
    chk("rd_data", rd_data, m_data);
    @(posedge clk);
    if (!rstn) model_reset();
    else begin
      if (m_we) begin m_rf[m_rd] = m_data; m_busy[m_rd] = 1'b0; end
      if (av && ar_exp && ar != 5'd0) m_busy[ar] = 1'b1;
      if (g0 || g1) begin
        m_rd   = g1 ? r1 : r0;
        m_data = g1 ? d1 : d0;
        m_we   = (m_rd != 5'd0);
        m_ptr  = g0;
      end else m_we = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] s1);
    step(0, 0, 0, 0, 0, 0, 0, 0, s1, 0);
  endtask

  logic [XLEN-1:0] saved;

  initial begin
    for (int i = 0; i < 32; i++) begin tb_rf[i] = '0; m_rf[i] = '0; end
    model_reset();
    rstn = 1'b0;
    @(negedge clk);

    // Reset held with an active requester: nothing accepted, nothing busy.
    step(1, 5, 10, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 10, 0, 0, 0, 0, 0, 5, 31);
    for (int i = 0; i < 32; i++) begin
      rs1 = i[4:0]; #1;
      chk("rst_rs1_busy", rs1_busy, 1'b0);
    end
    rstn = 1'b1;

    // Single path through x7.
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step(1, 7, 64'hAB, 0, 0, 0, 0, 0, 7, 0);
    chk("sp_rd", rd, 5'd7);
    chk("sp_data", rd_data, 64'hAB);
    chk("sp_we", write_en, 1'b1);
    idle(7);
    idle(7);
    chk("rf_x7", tb_rf[7], 64'hAB);

    // x0 write via req1 is consumed with no register-file effect; also re-favours req0.
    step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    idle(0);
    chk("rf_x0", tb_rf[0], 64'h0);

    // Contention: grants alternate starting with req0.
    for (int i = 0; i < 4; i++) step(1, 3, 64'h300 + i, 1, 4, 64'h400 + i, 0, 0, 3, 4);
    idle(0);
    idle(0);
    chk("rf_x3", tb_rf[3], 64'h302);
    chk("rf_x4", tb_rf[4], 64'h403);

    // WAW stall, then set-over-clear on an unreserved write to x9.
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    step(1, 9, 64'h91, 0, 0, 0, 1, 9, 9, 0);
    idle(9);
    idle(9);
    step(0, 0, 0, 1, 9, 64'h92, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    idle(9);
    chk("soc_busy9", rs1_busy, 1'b1);

    // Randomised traffic on a small register window to provoke hazards.
    for (int n = 0; n < 400; n++)
      step($urandom_range(1, 0), 5'($urandom_range(7, 0)), {$urandom, $urandom},
           $urandom_range(1, 0), 5'($urandom_range(7, 0)), {$urandom, $urandom},
           $urandom_range(1, 0), 5'($urandom_range(7, 0)),
           5'($urandom_range(7, 0)), 5'($urandom_range(31, 0)));
    for (int i = 0; i < 4; i++) idle(0);
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (tb_rf[i] !== m_rf[i]) begin
        n_errors++;
        $display("FAIL rf_final[%0d]: got %0h expected %0h", i, tb_rf[i], m_rf[i]);
      end
    end

    // Mid-operation reset between handshake and write edge.
    step(0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    step(1, 12, 64'h55, 0, 0, 0, 1, 13, 12, 13);
    chk("mr_we_before", write_en, 1'b1);
    saved = m_rf[12];
    rstn = 1'b0;
    #1;
    chk("mr_we", write_en, 1'b0);
    chk("mr_rd", rd, 5'd0);
    chk("mr_data", rd_data, 64'h0);
    for (int i = 0; i < 32; i++) begin
      rs2 = i[4:0]; #1;
      chk("mr_rs2_busy", rs2_busy, 1'b0);
    end
    model_reset();
    idle(12);
    chk("mr_rf_x12", tb_rf[12], saved);
    rstn = 1'b1;
    step(1, 12, 64'h66, 0, 0, 0, 0, 0, 12, 0);
    idle(12);
    idle(12);
    chk("post_rf_x12", tb_rf[12], 64'h66);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
